// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle MIPS32 control sequencer (FETCH/DECODE/EXEC/MEM/WB)
// Ports:
//   clk, reset_n        rising-edge clock, async active-low reset
//   start               leave IDLE and begin fetching
//   OpCode              instr[31:26], sampled in DECODE
//   mem_ready           shared memory finished the current access
//   PCWrite..PCSource   datapath controls (registered Moore decode of the state)
//   instr_done          one-cycle pulse when an instruction retires
//   retired             saturating count of retired instructions
//   illegal_op          sticky: undecodable opcode seen
//   mem_fault           sticky: mem_ready timed out
module multicycle_control_fsm #(
  parameter int OP_W = 6,
  parameter int WAIT_W = 4,
  parameter int MEM_TIMEOUT = 8,
  parameter int EN_JUMP = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [OP_W-1:0]  OpCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemToRead,
  output logic             MemToWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       AluOp,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_op,
  output logic             mem_fault
);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2b);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'h0d);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'h0c);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'h0a);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);

  typedef enum logic [3:0] {
    sIdle, sFetch, sDecode, sMaddr, sMrd, sMwb, sMwr,
    sREx, sRWb, sIEx, sIWb, sBr, sJmp, sFault
  } stateT;

  // fetch/memWr/done mark states whose strobes are qualified by mem_ready
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       fetch;
    logic       memWr;
    logic       done;
  } ctrlT;

  stateT            state, nextState;
  logic [OP_W-1:0]  opQ;
  logic [WAIT_W-1:0] waitCnt;
  ctrlT             ctrlQ;
  logic             waiting, timeout;

  function automatic ctrlT decode(input stateT s, input logic [OP_W-1:0] op);
    ctrlT c;
    c = '0;
    case (s)
      sFetch:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; c.fetch = 1'b1; end
      sDecode: c.aluSrcB = 2'b11;
      sMaddr:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      sMrd:    begin c.memRead = 1'b1; c.iorD = 1'b1; end
      sMwb:    begin c.regWrite = 1'b1; c.memToReg = 1'b1; c.done = 1'b1; end
      sMwr:    begin c.memWrite = 1'b1; c.iorD = 1'b1; c.memWr = 1'b1; end
      sREx:    begin c.aluSrcA = 1'b1; c.aluOp = 3'b010; end
      sRWb:    begin c.regWrite = 1'b1; c.regDst = 1'b1; c.done = 1'b1; end
      sIEx: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        c.aluOp = op == OP_ORI ? 3'b011 : op == OP_ANDI ? 3'b101 : op == OP_SLTI ? 3'b100 : 3'b000;
      end
      sIWb:    begin c.regWrite = 1'b1; c.done = 1'b1; end
      sBr: begin
        c.aluSrcA = 1'b1;
        c.aluOp = 3'b001;
        c.pcWriteCond = 1'b1;
        c.pcSource = 2'b01;
        c.done = 1'b1;
      end
      sJmp:    begin c.pcWrite = 1'b1; c.pcSource = 2'b10; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign waiting = (state == sFetch || state == sMrd || state == sMwr) && !mem_ready;
  // A ready on the limit cycle is not "waiting", so it never faults
  assign timeout = waiting && MEM_TIMEOUT != 0 && waitCnt == WAIT_W'(MEM_TIMEOUT - 1);

  always_comb begin
    nextState = state;
    case (state)
      sIdle:   nextState = start ? sFetch : sIdle;
      sFetch:  nextState = mem_ready ? sDecode : sFetch;
      sDecode:
        nextState = OpCode == OP_R ? sREx :
                    (OpCode == OP_LW || OpCode == OP_SW) ? sMaddr :
                    (OpCode == OP_ORI || OpCode == OP_ANDI || OpCode == OP_ADDI || OpCode == OP_SLTI) ? sIEx :
                    OpCode == OP_BEQ ? sBr :
                    (OpCode == OP_J && EN_JUMP != 0) ? sJmp : sFault;
      sMaddr:  nextState = opQ == OP_LW ? sMrd : sMwr;
      sMrd:    nextState = mem_ready ? sMwb : sMrd;
      sMwr:    nextState = mem_ready ? sFetch : sMwr;
      sREx:    nextState = sRWb;
      sIEx:    nextState = sIWb;
      sMwb, sRWb, sIWb, sBr, sJmp: nextState = sFetch;
      default: nextState = state;
    endcase
    if (timeout) nextState = sFault;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= sIdle;
      opQ        <= '0;
      waitCnt    <= '0;
      retired    <= '0;
      illegal_op <= 1'b0;
      mem_fault  <= 1'b0;
      ctrlQ      <= '0;
    end else begin
      state <= nextState;
      if (state == sDecode) opQ <= OpCode;
      waitCnt <= nextState != state ? '0 : (waiting && waitCnt != '1) ? waitCnt + 1'b1 : waitCnt;
      if (instr_done && retired != '1) retired <= retired + 1'b1;
      illegal_op <= illegal_op | (state == sDecode && nextState == sFault);
      mem_fault  <= mem_fault | timeout;
      // Outputs are registered from the upcoming state so they line up with it
      ctrlQ <= decode(nextState, state == sDecode ? OpCode : opQ);
    end
  end

  assign PCWrite     = ctrlQ.pcWrite | (ctrlQ.fetch & mem_ready);
  assign IRWrite     = ctrlQ.fetch & mem_ready;
  assign instr_done  = ctrlQ.done | (ctrlQ.memWr & mem_ready);
  assign PCWriteCond = ctrlQ.pcWriteCond;
  assign IorD        = ctrlQ.iorD;
  assign MemToRead   = ctrlQ.memRead;
  assign MemToWrite  = ctrlQ.memWrite;
  assign MemToReg    = ctrlQ.memToReg;
  assign RegDst      = ctrlQ.regDst;
  assign RegWrite    = ctrlQ.regWrite;
  assign ALUSrcA     = ctrlQ.aluSrcA;
  assign ALUSrcB     = ctrlQ.aluSrcB;
  assign AluOp       = ctrlQ.aluOp;
  assign PCSource    = ctrlQ.pcSource;
endmodule
